// File: rtl/matmul_seq_pkg.sv
// rtl/matmul_seq_pkg.sv - shared widths and state encoding for the matmul job sequencer
package matmul_seq_pkg;

   localparam int DIM_MAX = 3;
   localparam int ELEM_W  = 8;
   localparam int RES_W   = 16;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_A  = 3'd1;
   localparam logic [2:0] ST_LOAD_B  = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_TX_REQ  = 3'd4;
   localparam logic [2:0] ST_TX_WAIT = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_LOAD_A  = ST_LOAD_A,
      S_LOAD_B  = ST_LOAD_B,
      S_COMPUTE = ST_COMPUTE,
      S_TX_REQ  = ST_TX_REQ,
      S_TX_WAIT = ST_TX_WAIT
   } state_t;

endpackage

// File: rtl/matmul_job_sequencer_if.sv
// rtl/matmul_job_sequencer_if.sv - uart/memory/calculator signals around the job sequencer
interface matmul_job_sequencer_if;
   import matmul_seq_pkg::*;

   logic [ELEM_W-1:0]                  rx_data;
   logic                               rx_valid;
   logic                               tx_busy;
   logic                               mult_done;
   logic [RES_W*DIM_MAX*DIM_MAX-1:0]   mult_result;
   logic                               mem_clr;
   logic                               a_we;
   logic                               b_we;
   logic [3:0]                         wr_addr;
   logic                               mult_start;
   logic [ELEM_W-1:0]                  tx_data;
   logic                               tx_start;
   logic [2:0]                         state;
   logic                               busy;
   logic                               err;
   logic                               ovr;

   modport slave (
      input  rx_data, rx_valid, tx_busy, mult_done, mult_result,
      output mem_clr, a_we, b_we, wr_addr, mult_start, tx_data, tx_start,
             state, busy, err, ovr
   );

   modport master (
      output rx_data, rx_valid, tx_busy, mult_done, mult_result,
      input  mem_clr, a_we, b_we, wr_addr, mult_start, tx_data, tx_start,
             state, busy, err, ovr
   );

endinterface

// File: rtl/matmul_tx_serializer.sv
// rtl/matmul_tx_serializer.sv - latches the product and streams 2*N*N bytes over the tx_busy handshake
module matmul_tx_serializer
   import matmul_seq_pkg::*;
#(
   parameter int DIM = DIM_MAX
) (
   input  logic                             bclk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             run,
   input  logic [1:0]                       n,
   input  logic [RES_W*DIM_MAX*DIM_MAX-1:0] result,
   input  logic                             tx_busy,
   output logic                             tx_start,
   output logic [ELEM_W-1:0]                tx_data,
   output logic                             in_wait,
   output logic                             done
);

   logic [RES_W*DIM_MAX*DIM_MAX-1:0] res_q;
   logic [1:0]                       r;
   logic [1:0]                       c;
   logic                             lo;
   logic                             seen_busy;
   logic [3:0]                       k;
   logic [RES_W-1:0]                 entry;
   logic                             last;

   assign k     = {2'b00, r} * 4'(DIM) + {2'b00, c};
   assign entry = res_q[{k, 4'b0000} +: RES_W];
   assign last  = lo && (r == n - 2'd1) && (c == n - 2'd1);
   assign done  = run && in_wait && seen_busy && !tx_busy && last;

   always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
         res_q     <= '0;
         r         <= '0;
         c         <= '0;
         lo        <= 1'b0;
         seen_busy <= 1'b0;
         in_wait   <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
      end else begin
         tx_start <= 1'b0;
         if (start) begin
            res_q     <= result;
            r         <= '0;
            c         <= '0;
            lo        <= 1'b0;
            seen_busy <= 1'b0;
            in_wait   <= 1'b0;
         end else if (run) begin
            if (!in_wait) begin
               if (!tx_busy) begin
                  tx_start  <= 1'b1;
                  tx_data   <= lo ? entry[7:0] : entry[15:8];
                  in_wait   <= 1'b1;
                  seen_busy <= 1'b0;
               end
            end else if (tx_busy) begin
               seen_busy <= 1'b1;
            end else if (seen_busy) begin
               // A byte is finished only after busy has both risen and fallen.
               in_wait <= 1'b0;
               lo      <= !lo;
               if (lo) begin
                  if (c == n - 2'd1) begin
                     c <= '0;
                     r <= (r == n - 2'd1) ? 2'd0 : r + 2'd1;
                  end else begin
                     c <= c + 2'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/matmul_job_sequencer.sv
// rtl/matmul_job_sequencer.sv - frame sequencer for the UART matrix multiplier; RX_TIMEOUT_EN adds a load timeout
module matmul_job_sequencer
   import matmul_seq_pkg::*;
#(
   parameter int DIM            = DIM_MAX,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    bclk,
   input  logic                    rst,
   matmul_job_sequencer_if.slave   bus
);

   state_t     st;
   logic [1:0] n;
   logic [1:0] row;
   logic [1:0] col;
   logic       mem_clr_q;
   logic       err_q;
   logic       ovr_q;
   logic       loading;
   logic       ser_start;
   logic       ser_wait;
   logic       ser_done;

   assign loading   = (st == S_LOAD_A) || (st == S_LOAD_B);
   assign ser_start = (st == S_COMPUTE) && bus.mult_done;

   assign bus.a_we       = bus.rx_valid && (st == S_LOAD_A);
   assign bus.b_we       = bus.rx_valid && (st == S_LOAD_B);
   assign bus.wr_addr    = {2'b00, row} * 4'(DIM) + {2'b00, col};
   assign bus.mult_start = (st == S_COMPUTE);
   assign bus.busy       = (st != S_IDLE);
   assign bus.mem_clr    = mem_clr_q;
   assign bus.err        = err_q;
   assign bus.ovr        = ovr_q;
   // The serializer owns the request/wait phase of a transmit.
   assign bus.state      = (st == S_TX_REQ && ser_wait) ? S_TX_WAIT : st;

`ifdef RX_TIMEOUT_EN
   logic [15:0] idle_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
         st        <= S_IDLE;
         n         <= '0;
         row       <= '0;
         col       <= '0;
         mem_clr_q <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef RX_TIMEOUT_EN
         idle_cnt  <= '0;
`endif
      end else begin
         mem_clr_q <= 1'b0;
         err_q     <= 1'b0;
         if (bus.rx_valid && (st == S_COMPUTE || st == S_TX_REQ))
            ovr_q <= 1'b1;
         case (st)
            S_IDLE: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data != '0 && bus.rx_data <= 8'(DIM)) begin
                     n         <= bus.rx_data[1:0];
                     mem_clr_q <= 1'b1;
                     row       <= '0;
                     col       <= '0;
                     ovr_q     <= 1'b0;
                     st        <= S_LOAD_A;
`ifdef RX_TIMEOUT_EN
                     idle_cnt  <= '0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (bus.rx_valid) begin
                  if (col == n - 2'd1) begin
                     col <= '0;
                     if (row == n - 2'd1) begin
                        row <= '0;
                        st  <= (st == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
                     end else begin
                        row <= row + 2'd1;
                     end
                  end else begin
                     col <= col + 2'd1;
                  end
               end
`ifdef RX_TIMEOUT_EN
               if (bus.rx_valid) begin
                  idle_cnt <= '0;
               end else if (loading && idle_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  idle_cnt <= '0;
                  err_q    <= 1'b1;
                  row      <= '0;
                  col      <= '0;
                  st       <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 16'd1;
               end
`endif
            end
            S_COMPUTE: begin
               if (bus.mult_done)
                  st <= S_TX_REQ;
            end
            S_TX_REQ: begin
               if (ser_done)
                  st <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   matmul_tx_serializer #(
      .DIM (DIM)
   ) u_tx (
      .bclk     (bclk),
      .rst      (rst),
      .start    (ser_start),
      .run      (st == S_TX_REQ),
      .n        (n),
      .result   (bus.mult_result),
      .tx_busy  (bus.tx_busy),
      .tx_start (bus.tx_start),
      .tx_data  (bus.tx_data),
      .in_wait  (ser_wait),
      .done     (ser_done)
   );

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// tb/tb_matmul_job_sequencer.sv - randomized frames against a queue-based reference model
module tb_matmul_job_sequencer;
   import matmul_seq_pkg::*;

   logic bclk = 1'b0;
   logic rst  = 1'b1;
   always #5 bclk = ~bclk;

   matmul_job_sequencer_if bus();

   matmul_job_sequencer #(
      .DIM            (3),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .bclk (bclk),
      .rst  (rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int busy_len = 2;
   int calc_dly = 2;
   int clr_cnt  = 0;
   int err_cnt  = 0;
   int          wr_q[$];
   logic [7:0]  tx_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge bclk) begin
      if (!rst) begin
         if (bus.a_we) wr_q.push_back(int'(bus.wr_addr));
         if (bus.b_we) wr_q.push_back(16 + int'(bus.wr_addr));
         if (bus.mem_clr) clr_cnt++;
         if (bus.err) err_cnt++;
         if (bus.tx_start) begin
            tx_q.push_back(bus.tx_data);
            check("tx_start_while_busy", {31'd0, bus.tx_busy}, 32'd0);
         end
      end
   end

   // uart_tx: busy rises 0..2 cycles after each request and holds for busy_len cycles
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge bclk);
         if (bus.tx_start === 1'b1) begin
            repeat ($urandom_range(0, 2)) @(posedge bclk);
            @(posedge bclk); #1 bus.tx_busy = 1'b1;
            repeat (busy_len) @(posedge bclk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Calculator: one done pulse calc_dly cycles after enable
   initial begin
      bus.mult_done = 1'b0;
      forever begin
         @(negedge bclk);
         if (bus.mult_start === 1'b1) begin
            repeat (calc_dly) @(posedge bclk);
            @(posedge bclk); #1 bus.mult_done = 1'b1;
            @(posedge bclk); #1 bus.mult_done = 1'b0;
            @(negedge bclk);
            check("mult_start_drop", {31'd0, bus.mult_start}, 32'd0);
            check("state_after_done", {29'd0, bus.state}, 32'd4);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge bclk); #1 bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge bclk); #1; end
   endtask

   function automatic logic [143:0] rand_res();
      logic [143:0] v;
      for (int i = 0; i < 9; i++) v[i*16 +: 16] = 16'($urandom);
      return v;
   endfunction

   task automatic clear_monitors();
      wr_q.delete();
      tx_q.delete();
      clr_cnt = 0;
      err_cnt = 0;
   endtask

   task automatic run_frame(input int n, input logic [143:0] res, input bit inject);
      int         exp_wr[$];
      logic [7:0] exp_tx[$];
      logic [15:0] e;
      int t;
      clear_monitors();
      bus.mult_result = res;
      send_byte(8'(n), $urandom_range(0, 2));
      check("ovr_cleared_by_size", {31'd0, bus.ovr}, 32'd0);
      for (int m = 0; m < 2; m++)
         for (int k = 0; k < n * n; k++) begin
            exp_wr.push_back(m * 16 + (k / n) * 3 + (k % n));
            send_byte(8'($urandom), $urandom_range(0, 2));
         end
      if (inject) send_byte(8'h5a, 0);
      t = 0;
      while (bus.busy && t < 5000) begin @(posedge bclk); #1; t++; end
      check("frame_done_in_time", {31'd0, t < 5000}, 32'd1);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            e = res[(r * 3 + c) * 16 +: 16];
            exp_tx.push_back(e[15:8]);
            exp_tx.push_back(e[7:0]);
         end
      check("wr_count", wr_q.size(), exp_wr.size());
      foreach (exp_wr[i])
         check($sformatf("wr[%0d]", i), (i < wr_q.size()) ? wr_q[i] : -1, exp_wr[i]);
      check("tx_count", tx_q.size(), exp_tx.size());
      foreach (exp_tx[i])
         check($sformatf("tx[%0d]", i), (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hffff, {24'd0, exp_tx[i]});
      check("mem_clr_count", clr_cnt, 1);
      check("err_count", err_cnt, 0);
      check("end_state", {29'd0, bus.state}, 32'd0);
      check("ovr", {31'd0, bus.ovr}, {31'd0, inject});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, {29'd0, bus.state}, 32'd0);
      check({tag, "_outs"},
            {20'd0, bus.busy, bus.err, bus.ovr, bus.mem_clr, bus.a_we, bus.b_we,
             bus.mult_start, bus.tx_start, bus.wr_addr}, 32'd0);
      check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
   endtask

   initial begin
      logic [143:0] res;
      bus.rx_data     = '0;
      bus.rx_valid    = 1'b0;
      bus.mult_result = '0;
      repeat (3) @(posedge bclk);
      #1 check_all_zero("reset");
      rst = 1'b0;
      @(posedge bclk); #1;

      // size 3, product entries 1..9
      for (int i = 0; i < 9; i++) res[i*16 +: 16] = 16'(i + 1);
      run_frame(3, res, 0);

      // size 2 picks entries 0,1,3,4
      run_frame(2, rand_res(), 0);

      // bad size bytes
      clear_monitors();
      send_byte(8'h00, 1);
      send_byte(8'h05, 1);
      check("bad_size_err", err_cnt, 2);
      check("bad_size_state", {29'd0, bus.state}, 32'd0);
      check("bad_size_writes", wr_q.size(), 0);
      check("bad_size_clr", clr_cnt, 0);

      // slow uart
      busy_len = 50;
      run_frame(3, rand_res(), 0);

      // overrun during compute, then cleared by the next frame
      busy_len = 2;
      calc_dly = 6;
      run_frame($urandom_range(1, 3), rand_res(), 1);

      for (int f = 0; f < 6; f++) begin
         busy_len = $urandom_range(1, 4);
         calc_dly = $urandom_range(0, 5);
         run_frame($urandom_range(1, 3), rand_res(), 0);
      end

      // reset in the middle of LOAD_B
      clear_monitors();
      send_byte(8'd3, 0);
      for (int k = 0; k < 13; k++) send_byte(8'($urandom), 0);
      check("pre_reset_state", {29'd0, bus.state}, 32'd2);
      rst = 1'b1;
      #1 check_all_zero("mid_reset");
      @(posedge bclk); #1 rst = 1'b0;
      @(posedge bclk); #1;
      check("reset_no_err", err_cnt, 0);
      run_frame(1, rand_res(), 0);

`ifdef RX_TIMEOUT_EN
      begin
         int cnt;
         clear_monitors();
         send_byte(8'd3, 0);
         for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
         cnt = 0;
         while (cnt < 300) begin
            @(negedge bclk);
            if (bus.err) break;
            @(posedge bclk);
            cnt++;
         end
         check("timeout_cycle", cnt, 100);
         check("timeout_state", {29'd0, bus.state}, 32'd0);
         @(posedge bclk); #1;
         check("timeout_err_count", err_cnt, 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

endmodule
